// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first frames with DBIT data bits and a stop bit
// lasting SB_TICK ticks. Reports each frame with a one-clock rx_done_tick and a stop-bit error flag.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk_50MHz,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            rx_s_q, rx_s_d;
  logic [3:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      rx_s_q  <= rx_s_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // rx_done_tick is registered so it rises together with the freshly loaded dout/frame_err.
  always_comb begin
    state_d = state_q;
    sync1_d = rx;
    rx_s_d  = sync1_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == 4'd7) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == 4'd15) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q == NW'(DBIT - 1)) begin
              state_d = STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == 4'(SB_TICK - 1)) begin
            state_d = IDLE;
            dout_d  = b_q;
            ferr_d  = ~rx_s_q;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a tick-accurate serial sender feeds frames and a
// queue of expected (data, frame_err) results is matched against every rx_done_tick.
module tb_uart_rx;

  localparam int TP = 4;  // clocks per s_tick (shortened to keep the run small)

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       s_tick;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk_50MHz    (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         pulses = 0;
  logic [7:0] model_dout = 8'h00;
  logic       model_ferr = 1'b0;
  bit         tick_en = 1'b1;

  // Tick generator: s_tick changes just after a rising edge, high for exactly one edge.
  initial begin
    int cnt;
    cnt = 0;
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_en) begin
        cnt = (cnt + 1) % TP;
        s_tick = (cnt == 0);
      end else begin
        s_tick = 1'b0;
      end
    end
  end

  // Scoreboard: every pulse must match the oldest outstanding frame.
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_done_tick === 1'b1) begin
        pulses++;
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_single_cycle: rx_done_tick high on consecutive clocks");
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: dout=%02h frame_err=%0b, no frame outstanding", dout, frame_err);
        end else begin
          e = exp_q.pop_front();
          if (dout !== e.data || frame_err !== e.ferr) begin
            errors++;
            $display("FAIL frame_result: dout=%02h frame_err=%0b, expected dout=%02h frame_err=%0b",
                     dout, frame_err, e.data, e.ferr);
          end
          model_dout = e.data;
          model_ferr = e.ferr;
        end
      end
      prev_done = (rx_done_tick === 1'b1);
    end
  end

  task automatic wait_ticks(input int k);
    for (int i = 0; i < k; i++) begin
      int guard;
      guard = 0;
      do begin
        @(posedge clk);
        guard++;
      end while (s_tick !== 1'b1 && guard < 100 * TP);
      if (s_tick !== 1'b1) begin
        $display("FAIL tick_timeout: no s_tick within %0d clocks", guard);
        $fatal(1, "tick generator stalled");
      end
    end
    #1;
  endtask

  task automatic idle_bits(input int nb);
    rx = 1'b1;
    wait_ticks(16 * nb);
  endtask

  // Sends one frame aligned to tick edges. freeze_bit/reset_bit select a data bit
  // during which ticks are paused or reset is pulsed (-1 = none).
  task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                            input int freeze_bit, input int reset_bit);
    exp_t e;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == reset_bit) begin
        wait_ticks(6);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rx = 1'b1;
        return;
      end else if (i == freeze_bit) begin
        wait_ticks(5);
        tick_en = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        tick_en = 1'b1;
        wait_ticks(11);
      end else begin
        wait_ticks(16);
      end
    end
    e.data = d;
    e.ferr = ~stop_ok;
    exp_q.push_back(e);
    if (stop_ok) begin
      rx = 1'b1;
      wait_ticks(16);
    end else begin
      // Low through the mid-stop sample, released just before the receiver looks for a new start.
      rx = 1'b0;
      wait_ticks(7);
      repeat (TP - 2) @(posedge clk);
      #1;
      rx = 1'b1;
      wait_ticks(9);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %02h want 00", dout); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %0b want 0", frame_err); end
    checks++;
    if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", rx_done_tick); end
    rx = 1'b1;
    reset = 1'b0;
    idle_bits(2);
  endtask

  task automatic test_basic;
    int p0;
    p0 = pulses;
    send_frame(8'hA5, 1'b1, -1, -1);
    idle_bits(2);
    checks++;
    if (pulses - p0 !== 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", pulses - p0); end
    checks++;
    if (dout !== 8'hA5 || frame_err !== 1'b0) begin
      errors++; $display("FAIL basic_hold: dout=%02h ferr=%0b want A5/0", dout, frame_err);
    end
  endtask

  task automatic test_false_start;
    int p0;
    logic [7:0] d0;
    logic f0;
    p0 = pulses;
    d0 = model_dout;
    f0 = model_ferr;
    rx = 1'b0;
    wait_ticks(3);
    idle_bits(12);
    checks++;
    if (pulses !== p0) begin errors++; $display("FAIL false_start_pulse: got %0d pulses want 0", pulses - p0); end
    checks++;
    if (dout !== d0 || frame_err !== f0) begin
      errors++; $display("FAIL false_start_hold: dout=%02h ferr=%0b want %02h/%0b", dout, frame_err, d0, f0);
    end
    send_frame(8'h5C, 1'b1, -1, -1);
    idle_bits(1);
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL false_start_recover: %0d frames unreceived", exp_q.size()); end
  endtask

  task automatic test_frame_err;
    send_frame(8'h3C, 1'b0, -1, -1);
    idle_bits(2);
    checks++;
    if (dout !== 8'h3C || frame_err !== 1'b1) begin
      errors++; $display("FAIL frame_err_set: dout=%02h ferr=%0b want 3C/1", dout, frame_err);
    end
    send_frame(8'h01, 1'b1, -1, -1);
    idle_bits(1);
    checks++;
    if (dout !== 8'h01 || frame_err !== 1'b0) begin
      errors++; $display("FAIL frame_err_clear: dout=%02h ferr=%0b want 01/0", dout, frame_err);
    end
  endtask

  task automatic test_back_to_back;
    int p0;
    p0 = pulses;
    send_frame(8'h00, 1'b1, -1, -1);
    send_frame(8'hFF, 1'b1, -1, -1);
    idle_bits(2);
    checks++;
    if (pulses - p0 !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses - p0); end
    checks++;
    if (dout !== 8'hFF) begin errors++; $display("FAIL b2b_last: dout=%02h want FF", dout); end
  endtask

  task automatic test_reset_mid_frame;
    int p0;
    p0 = pulses;
    send_frame(8'h77, 1'b1, -1, 4);
    model_dout = 8'h00;
    model_ferr = 1'b0;
    @(negedge clk);
    checks++;
    if (dout !== 8'h00 || frame_err !== 1'b0) begin
      errors++; $display("FAIL midreset_clear: dout=%02h ferr=%0b want 00/0", dout, frame_err);
    end
    idle_bits(12);
    checks++;
    if (pulses !== p0) begin errors++; $display("FAIL midreset_pulse: got %0d pulses want 0", pulses - p0); end
    send_frame(8'h5A, 1'b1, -1, -1);
    idle_bits(1);
    checks++;
    if (dout !== 8'h5A || exp_q.size() !== 0) begin
      errors++; $display("FAIL midreset_next: dout=%02h pending=%0d want 5A/0", dout, exp_q.size());
    end
  endtask

  task automatic test_tick_freeze;
    int p0;
    p0 = pulses;
    send_frame(8'hC3, 1'b1, 3, -1);
    idle_bits(1);
    checks++;
    if (pulses - p0 !== 1 || dout !== 8'hC3) begin
      errors++; $display("FAIL freeze_frame: pulses=%0d dout=%02h want 1/C3", pulses - p0, dout);
    end
  endtask

  task automatic test_random;
    int p0;
    int nexp;
    p0 = pulses;
    nexp = 0;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      bit ok;
      d  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      send_frame(d, ok, -1, -1);
      nexp++;
      if ($urandom_range(0, 1) == 1) idle_bits($urandom_range(1, 2));
    end
    idle_bits(2);
    checks++;
    if (pulses - p0 !== nexp) begin errors++; $display("FAIL random_pulses: got %0d want %0d", pulses - p0, nexp); end
    checks++;
    if (dout !== model_dout || frame_err !== model_ferr) begin
      errors++; $display("FAIL random_hold: dout=%02h ferr=%0b want %02h/%0b", dout, frame_err, model_dout, model_ferr);
    end
  endtask

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_tick_freeze();
    test_random();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL final_drain: %0d frames never reported", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
